modinv: RTL



---
 rtl/modinv_pkg.sv | 21 ++
 rtl/divide.sv | 57 +++++
 rtl/modinv_seq_mul.sv | 52 +++++
 rtl/modinv.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/modinv_pkg.sv
// Shared definitions for the modular-inverse block: controller states and
// the operand-width convention (operands are twice the half width).
package modinv_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int OPW_DEF   = 2 * WIDTH_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_MUL,
    S_UPD,
    S_FIX,
    S_DONE
  } state_t;

  function automatic int opw(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/divide.sv
// Team restoring divider: one quotient bit per cycle, start/finish handshake.
// quotient/remainder are valid while finish is high and held afterwards.
module Divide #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finish
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;
  logic          active;
  logic [WIDTH:0] rem_sh;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign rem_sh = {remainder, quotient[WIDTH-1]};

  // NOTE: every register here is sequential state, so all updates are non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      count     <= '0;
      active    <= 1'b0;
      finish    <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (start) begin
        quotient  <= dividend;
        remainder <= '0;
        count     <= CW'(WIDTH);
        active    <= 1'b1;
      end else if (active) begin
        if (rem_sh >= {1'b0, divisor}) begin
          remainder <= WIDTH'(rem_sh - {1'b0, divisor});
          quotient  <= {quotient[WIDTH-2:0], 1'b1};
        end else begin
          remainder <= rem_sh[WIDTH-1:0];
          quotient  <= {quotient[WIDTH-2:0], 1'b0};
        end
        count <= count - 1'b1;
        if (count == CW'(1)) begin
          active <= 1'b0;
          finish <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modinv_seq_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle. The product is
// kept modulo 2**PW so callers can size it to the range they actually need.
module seq_mul #(
  parameter int WIDTH = 16,
  parameter int PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [PW-1:0]    product,
  output logic             finish
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    count;
  logic             active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      count   <= '0;
      active  <= 1'b0;
      finish  <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (start) begin
        product <= '0;
        a_sh    <= PW'(a);
        b_sh    <= b;
        count   <= CW'(WIDTH);
        active  <= 1'b1;
      end else if (active) begin
        if (b_sh[0]) product <= product + a_sh;
        a_sh  <= a_sh << 1;
        b_sh  <= b_sh >> 1;
        count <= count - 1'b1;
        if (count == CW'(1)) begin
          active <= 1'b0;
          finish <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modinv.sv
// d = e^-1 mod phi by iterative extended Euclid: Divide supplies q/rem each
// round, seq_mul forms q*t, and the final Bezout coefficient is folded into [0, phi).
module modinv
  import modinv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   e,
  input  logic [2*WIDTH-1:0]   phi,
  output logic [2*WIDTH-1:0]   d,
  output logic                 finish,
  output logic                 err,
  output logic                 busy
);

  localparam int OPW = opw(WIDTH);

  state_t state, state_nx;

  logic [OPW-1:0]        r_old, r, q, rem, phi_l;
  logic signed [OPW:0]   t_old, t, prod;
  logic                  err_flag, div_start, mul_start;
  logic [OPW-1:0]        div_q, div_rem, t_mag;
  logic                  div_finish, mul_finish;
  logic [OPW:0]          mul_p, fix_pos;
  logic                  fix_ge, legal;

  assign legal = (phi >= OPW'(2)) && (e != '0) && (e < phi);

  // |t| fits in OPW bits because the Euclid bound keeps |t| <= phi.
  assign t_mag = t[OPW] ? (~t[OPW-1:0] + 1'b1) : t[OPW-1:0];

  assign fix_pos = t[OPW] ? ($unsigned(t) + {1'b0, phi_l}) : $unsigned(t);
  assign fix_ge  = fix_pos[OPW] || (fix_pos[OPW-1:0] >= phi_l);

  Divide #(.WIDTH(OPW)) u_div (
    .clk       (clk),
    .rst_n     (~rst),
    .start     (div_start),
    .dividend  (r_old),
    .divisor   (r),
    .quotient  (div_q),
    .remainder (div_rem),
    .finish    (div_finish)
  );

  seq_mul #(.WIDTH(OPW), .PW(OPW + 1)) u_mul (
    .clk     (clk),
    .rst_n   (~rst),
    .start   (mul_start),
    .a       (div_q),
    .b       (t_mag),
    .product (mul_p),
    .finish  (mul_finish)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = legal ? S_DIV : S_DONE;
      S_DIV: begin
        if (div_finish) begin
          if (div_rem != '0) begin
            state_nx  = S_MUL;
            mul_start = 1'b1;
          end else begin
            state_nx = (r == OPW'(1)) ? S_FIX : S_DONE;
          end
        end
      end
      S_MUL:   if (mul_finish) state_nx = S_UPD;
      S_UPD:   state_nx = S_DIV;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_old     <= '0;
      r         <= '0;
      t_old     <= '0;
      t         <= '0;
      q         <= '0;
      rem       <= '0;
      prod      <= '0;
      phi_l     <= '0;
      err_flag  <= 1'b0;
      div_start <= 1'b0;
      d         <= '0;
      finish    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      finish    <= 1'b0;
      err       <= 1'b0;
      div_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            d        <= '0;
            err_flag <= !legal;
            if (legal) begin
              r_old     <= phi;
              r         <= e;
              t_old     <= '0;
              t         <= {{OPW{1'b0}}, 1'b1};
              phi_l     <= phi;
              div_start <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (div_finish) begin
            q   <= div_q;
            rem <= div_rem;
            if (div_rem == '0 && r != OPW'(1)) err_flag <= 1'b1;
          end
        end
        S_MUL: if (mul_finish) prod <= t[OPW] ? -$signed(mul_p) : $signed(mul_p);
        S_UPD: begin
          r_old     <= r;
          r         <= rem;
          t_old     <= t;
          t         <= t_old - prod;
          div_start <= 1'b1;
        end
        S_FIX: d <= fix_ge ? (fix_pos[OPW-1:0] - phi_l) : fix_pos[OPW-1:0];
        S_DONE: begin
          finish <= 1'b1;
          err    <= err_flag;
          busy   <= 1'b0;
          if (err_flag) d <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
